// File: rtl/seven_segment_pkg.sv
// Shared constants and hex-to-segment decode for the 7-segment display designs.
package seven_segment_pkg;

  localparam int         N_DIGITS  = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low pattern, bit 0 = segment a .. bit 6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern.
module hex_to_seg7
  import seven_segment_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// 4-digit common-anode 7-segment scanner with frame-synchronous load and
// per-slot dead time. Optional macro SEVEN_SEGMENT_SCANNER_DIMMING_EN adds a
// brightness input that gates the anodes from the top prescaler bits.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int CLK_DIV_W   = 16,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                mclk,
  input  logic                reset,
  input  logic [15:0]         value,
  input  logic [N_DIGITS-1:0] dp_in,
  input  logic [N_DIGITS-1:0] blank_in,
  input  logic                load,
`ifdef SEVEN_SEGMENT_SCANNER_DIMMING_EN
  input  logic [3:0]          brightness,
`endif
  output logic                load_ack,
  output logic                frame_start,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an
);

  localparam int                   DIG_W  = $clog2(N_DIGITS);
  localparam logic [CLK_DIV_W-1:0] DEAD_Q = CLK_DIV_W'(DEAD_CYCLES);

  logic [CLK_DIV_W-1:0] r_presc;
  logic [DIG_W-1:0]     r_digit;

  logic [15:0]          r_disp_value;
  logic [N_DIGITS-1:0]  r_disp_dp;
  logic [N_DIGITS-1:0]  r_disp_blank;
  logic [15:0]          r_pend_value;
  logic [N_DIGITS-1:0]  r_pend_dp;
  logic [N_DIGITS-1:0]  r_pend_blank;
  logic                 r_pend_flag;

  logic                 r_load_ack;
  logic                 r_frame_start;
  logic [6:0]           r_seg;
  logic                 r_dp;
  logic [N_DIGITS-1:0]  r_an;

  logic                 w_tc;
  logic                 w_boundary;
  logic [3:0]           w_nibble;
  logic [6:0]           w_seg;
  logic                 w_dim_ok;
  logic                 w_lit;
  logic [N_DIGITS-1:0]  w_an_sel;

  assign w_tc       = &r_presc;
  assign w_boundary = w_tc && (r_digit == DIG_W'(N_DIGITS - 1));
  assign w_nibble   = r_disp_value[{r_digit, 2'b00} +: 4];
  assign w_an_sel   = ~(N_DIGITS'(1) << r_digit);

`ifdef SEVEN_SEGMENT_SCANNER_DIMMING_EN
  assign w_dim_ok = r_presc[CLK_DIV_W-1 -: 4] < brightness;
`else
  assign w_dim_ok = 1'b1;
`endif

  // Digit is driven only past the dead time, when not blanked and within duty.
  assign w_lit = (r_presc >= DEAD_Q) && !r_disp_blank[r_digit] && w_dim_ok;

  hex_to_seg7 u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Scan counters and the pending/displayed double buffer.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_presc      <= '0;
      r_digit      <= '0;
      r_disp_value <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '0;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_flag  <= 1'b0;
    end else begin
      r_presc <= r_presc + CLK_DIV_W'(1);
      if (w_tc) begin
        r_digit <= r_digit + DIG_W'(1);
      end
      if (w_boundary && r_pend_flag) begin
        r_disp_value <= r_pend_value;
        r_disp_dp    <= r_pend_dp;
        r_disp_blank <= r_pend_blank;
      end
      // A load on the boundary cycle re-arms the flag after the transfer.
      if (load) begin
        r_pend_value <= value;
        r_pend_dp    <= dp_in;
        r_pend_blank <= blank_in;
        r_pend_flag  <= 1'b1;
      end else if (w_boundary) begin
        r_pend_flag  <= 1'b0;
      end
    end
  end

  // Registered display drive and status pulses from the current scan state.
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_an          <= '1;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_lit ? w_an_sel : '1;
      r_seg         <= w_lit ? w_seg : SEG_BLANK;
      r_dp          <= w_lit ? ~r_disp_dp[r_digit] : 1'b1;
      r_load_ack    <= w_boundary && r_pend_flag;
      r_frame_start <= w_boundary;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign load_ack    = r_load_ack;
  assign frame_start = r_frame_start;

endmodule
